ps2_key_event_sequencer: RTL and testbench

//   Sequences the byte stream from the PS/2 receiver into whole key events (make/break, extended).

---
 rtl/ps2_key_event_sequencer_pkg.sv | 55 +++++
 rtl/ps2_key_event_sequencer_if.sv | 28 ++
 rtl/ps2_key_event_sequencer_fifo.sv | 55 +++++
 rtl/ps2_key_event_sequencer.sv | 135 +++++++++++++
 tb/tb_ps2_key_event_sequencer.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/ps2_key_event_sequencer_pkg.sv
// rtl/ps2_key_event_sequencer_pkg.sv - scan codes, sequencer state and event payload shared by the PS/2 key path
package ps2_pkg;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_BAT_OK = 8'hAA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ERR_LO = 8'h00;
  localparam logic [7:0] SC_ERR_HI = 8'hFF;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_SPACE  = 8'h29;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GOT_E0,
    ST_GOT_F0,
    ST_GOT_E0F0
  } ps2_seq_state_t;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } ps2_key_evt_t;

  // Keyboard housekeeping bytes that never describe a key when seen outside a prefix.
  function automatic logic is_protocol_byte(input logic [7:0] b);
    return (b == SC_ACK) || (b == SC_BAT_OK) || (b == SC_ECHO) ||
           (b == SC_RESEND) || (b == SC_ERR_LO) || (b == SC_ERR_HI);
  endfunction

  // One-hot position in {space, right, left, down, up}, zero for untracked keys.
  function automatic logic [4:0] game_key_mask(input ps2_key_evt_t e);
    logic [4:0] m;
    m = 5'b00000;
    if (e.ext) begin
      case (e.code)
        SC_UP:    m = 5'b00001;
        SC_DOWN:  m = 5'b00010;
        SC_LEFT:  m = 5'b00100;
        SC_RIGHT: m = 5'b01000;
        default:  m = 5'b00000;
      endcase
    end else if (e.code == SC_SPACE) begin
      m = 5'b10000;
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_key_event_sequencer_if.sv
// rtl/ps2_key_event_sequencer_if.sv - byte input, event output and status bundle of the key sequencer
interface ps2_key_event_sequencer_if;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_err;
  logic       clr_status;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic [4:0] keys_held;
  logic       seq_err;
  logic       overflow;
  logic [7:0] rx_err_cnt;

  modport master (
    output byte_valid, byte_data, byte_err, clr_status, evt_ready,
    input  evt_valid, evt_code, evt_ext, evt_break, keys_held, seq_err, overflow, rx_err_cnt
  );

  modport slave (
    input  byte_valid, byte_data, byte_err, clr_status, evt_ready,
    output evt_valid, evt_code, evt_ext, evt_break, keys_held, seq_err, overflow, rx_err_cnt
  );

endinterface

// File: rtl/ps2_key_event_sequencer_fifo.sv
// rtl/ps2_key_event_sequencer_fifo.sv - first-word fall-through FIFO of key events
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       wr_en_i,
  input  ps2_key_evt_t               wr_data_i,
  input  logic                       rd_en_i,
  output ps2_key_evt_t               rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  ps2_key_evt_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_pop, do_push;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign do_pop  = rd_en_i & ~empty_o;
  assign do_push = wr_en_i & (~full_o | do_pop);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_event_sequencer.sv
// rtl/ps2_key_event_sequencer.sv - turns PS/2 scan bytes into buffered make/break key events
module ps2_key_event_sequencer
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  ps2_key_event_sequencer_if.slave    bus
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ps2_seq_state_t state_q;
  logic [TW-1:0]  tmo_q;
  logic [4:0]     keys_q;
  logic           seq_err_q, overflow_q;
  logic [7:0]     rx_err_cnt_q;

  logic           accept, rx_bad, timed_out;
  logic           emit, bad_prefix, is_e0, is_f0;
  ps2_key_evt_t   evt_d, head;
  logic           fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count;

  assign accept  = bus.byte_valid & ~bus.byte_err;
  assign rx_bad  = bus.byte_valid &  bus.byte_err;
  assign is_e0   = (bus.byte_data == SC_E0);
  assign is_f0   = (bus.byte_data == SC_F0);
  assign timed_out = (state_q != ST_IDLE) && !bus.byte_valid && (tmo_q == TMO_LAST);

  always_comb begin
    emit       = 1'b0;
    bad_prefix = 1'b0;
    evt_d      = '{brk: 1'b0, ext: 1'b0, code: bus.byte_data};
    if (accept) begin
      unique case (state_q)
        ST_IDLE:   emit = !is_e0 && !is_f0 && !is_protocol_byte(bus.byte_data);
        ST_GOT_E0: begin
          evt_d.ext  = 1'b1;
          emit       = !is_e0 && !is_f0;
          bad_prefix = is_e0;
        end
        ST_GOT_F0: begin
          evt_d.brk  = 1'b1;
          emit       = !is_e0 && !is_f0;
          bad_prefix = is_e0 || is_f0;
        end
        ST_GOT_E0F0: begin
          evt_d.brk  = 1'b1;
          evt_d.ext  = 1'b1;
          emit       = !is_e0 && !is_f0;
          bad_prefix = is_e0 || is_f0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      tmo_q   <= '0;
    end else if (rx_bad) begin
      state_q <= ST_IDLE;
      tmo_q   <= '0;
    end else if (accept) begin
      tmo_q <= '0;
      unique case (state_q)
        ST_IDLE:     state_q <= is_e0 ? ST_GOT_E0 : (is_f0 ? ST_GOT_F0 : ST_IDLE);
        ST_GOT_E0:   state_q <= is_f0 ? ST_GOT_E0F0 : (is_e0 ? ST_GOT_E0 : ST_IDLE);
        ST_GOT_F0:   state_q <= ST_IDLE;
        ST_GOT_E0F0: state_q <= ST_IDLE;
      endcase
    end else if (timed_out) begin
      state_q <= ST_IDLE;
      tmo_q   <= '0;
    end else if (state_q != ST_IDLE) begin
      tmo_q <= tmo_q + TW'(1);
    end
  end

  // Held state follows every decoded event, whether or not the FIFO keeps it.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      keys_q <= '0;
    end else if (emit) begin
      if (evt_d.brk) keys_q <= keys_q & ~game_key_mask(evt_d);
      else           keys_q <= keys_q |  game_key_mask(evt_d);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      seq_err_q    <= 1'b0;
      overflow_q   <= 1'b0;
      rx_err_cnt_q <= '0;
    end else begin
      if (bad_prefix || timed_out) seq_err_q <= 1'b1;
      else if (bus.clr_status)     seq_err_q <= 1'b0;

      if (emit && fifo_full && !bus.evt_ready) overflow_q <= 1'b1;
      else if (bus.clr_status)                 overflow_q <= 1'b0;

      if (rx_bad)                  rx_err_cnt_q <= (rx_err_cnt_q == 8'hFF) ? 8'hFF : rx_err_cnt_q + 8'd1;
      else if (bus.clr_status)     rx_err_cnt_q <= '0;
    end
  end

  ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .wr_en_i   (emit),
    .wr_data_i (evt_d),
    .rd_en_i   (bus.evt_ready),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  always_comb assert (fifo_full == (fifo_count == CW'(FIFO_DEPTH)));

  assign bus.evt_valid  = ~fifo_empty;
  assign bus.evt_code   = head.code;
  assign bus.evt_ext    = head.ext;
  assign bus.evt_break  = head.brk;
  assign bus.keys_held  = keys_q;
  assign bus.seq_err    = seq_err_q;
  assign bus.overflow   = overflow_q;
  assign bus.rx_err_cnt = rx_err_cnt_q;

endmodule

// File: tb/tb_ps2_key_event_sequencer.sv
// tb/tb_ps2_key_event_sequencer.sv - scoreboard bench for the PS/2 key event sequencer
module tb_ps2_key_event_sequencer;

  localparam int TMO = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [9:0] exp_q[$];
  logic [4:0] exp_keys = '0;

  always #5 clk = ~clk;

  ps2_key_event_sequencer_if bus();

  ps2_key_event_sequencer #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference key tracker plus scoreboard push for an event the bench expects to be decoded.
  task automatic expect_evt(input logic brk, input logic ext, input logic [7:0] code, input bit queued);
    logic [4:0] m;
    m = 5'b0;
    if (ext && code == 8'h75) m = 5'b00001;
    if (ext && code == 8'h72) m = 5'b00010;
    if (ext && code == 8'h6B) m = 5'b00100;
    if (ext && code == 8'h74) m = 5'b01000;
    if (!ext && code == 8'h29) m = 5'b10000;
    exp_keys = brk ? (exp_keys & ~m) : (exp_keys | m);
    if (queued) exp_q.push_back({brk, ext, code});
  endtask

  task automatic send(input logic [7:0] b, input logic err = 1'b0);
    @(posedge clk); #1;
    bus.byte_valid = 1'b1; bus.byte_data = b; bus.byte_err = err;
    @(posedge clk); #1;
    bus.byte_valid = 1'b0; bus.byte_err = 1'b0;
  endtask

  task automatic send_pop(input logic [7:0] b);
    @(posedge clk); #1;
    bus.byte_valid = 1'b1; bus.byte_data = b; bus.evt_ready = 1'b1;
    @(posedge clk); #1;
    bus.byte_valid = 1'b0; bus.evt_ready = 1'b0;
  endtask

  task automatic clr();
    @(posedge clk); #1 bus.clr_status = 1'b1;
    @(posedge clk); #1 bus.clr_status = 1'b0;
  endtask

  task automatic drain(input string tag);
    bus.evt_ready = 1'b1;
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk(tag, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.evt_valid && bus.evt_ready) begin
      if (exp_q.size() == 0) chk("unexpected_evt", {bus.evt_break, bus.evt_ext, bus.evt_code}, 32'h3FF0000);
      else chk("evt", {bus.evt_break, bus.evt_ext, bus.evt_code}, exp_q.pop_front());
    end
  end

  initial begin
    bus.byte_valid = 0; bus.byte_data = 0; bus.byte_err = 0;
    bus.clr_status = 0; bus.evt_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_valid", bus.evt_valid, 0);
    chk("rst_keys", bus.keys_held, 0);
    chk("rst_flags", {bus.seq_err, bus.overflow, bus.rx_err_cnt}, 0);

    bus.evt_ready = 0;
    expect_evt(0, 0, 8'h1C, 1);
    send(8'h1C);
    chk("lat_valid", bus.evt_valid, 1);
    chk("lat_head", {bus.evt_break, bus.evt_ext, bus.evt_code}, 10'h01C);
    drain("drain_make");

    expect_evt(1, 0, 8'h1C, 1);
    send(8'hF0); send(8'h1C);
    drain("drain_break");

    expect_evt(0, 1, 8'h75, 1);
    send(8'hE0); send(8'h75);
    chk("keys_up_make", bus.keys_held, exp_keys);
    expect_evt(1, 1, 8'h75, 1);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("keys_up_break", bus.keys_held, exp_keys);
    drain("drain_ext");

    bus.evt_ready = 0;
    expect_evt(0, 0, 8'h1C, 1); send(8'h1C);
    expect_evt(0, 0, 8'h1B, 1); send(8'h1B);
    expect_evt(0, 0, 8'h23, 1); send(8'h23);
    expect_evt(0, 0, 8'h2B, 1); send(8'h2B);
    chk("no_ovf_at_full", bus.overflow, 0);
    expect_evt(0, 0, 8'h29, 0); send(8'h29);
    chk("ovf_set", bus.overflow, 1);
    chk("keys_on_drop", bus.keys_held, 5'b10000);
    clr();
    chk("ovf_clr", bus.overflow, 0);
    expect_evt(0, 0, 8'h34, 1);
    send_pop(8'h34);
    chk("full_push_pop_ovf", bus.overflow, 0);
    drain("drain_full");

    send(8'hE0);
    repeat (TMO + 3) @(posedge clk);
    #1 chk("timeout_seq_err", bus.seq_err, 1);
    expect_evt(0, 0, 8'h29, 1);
    send(8'h29);
    drain("drain_timeout");
    clr();
    chk("seq_err_clr", bus.seq_err, 0);

    send(8'hF0, 1'b1);
    expect_evt(0, 0, 8'h1C, 1);
    send(8'h1C);
    chk("rx_err_cnt", bus.rx_err_cnt, 1);
    drain("drain_err");
    send(8'hFA); send(8'hAA);
    repeat (2) @(posedge clk);
    #1 chk("proto_dropped", bus.evt_valid, 0);

    send(8'hF0); send(8'hE0);
    chk("f0_e0_seq_err", bus.seq_err, 1);
    chk("f0_e0_no_evt", bus.evt_valid, 0);

    send(8'hE0); send(8'hF0);
    @(posedge clk); #1 rst_n = 1'b0;
    exp_keys = '0;
    #3;
    chk("rst_mid_keys", bus.keys_held, 0);
    chk("rst_mid_flags", {bus.seq_err, bus.overflow, bus.rx_err_cnt}, 0);
    chk("rst_mid_valid", bus.evt_valid, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    expect_evt(0, 0, 8'h75, 1);
    send(8'h75);
    chk("after_rst_keys", bus.keys_held, exp_keys);
    drain("drain_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
